// File: rtl/reg_file_pkg.sv
// ============================================================================
//  Module   : reg_file_pkg
//  Purpose  : Shared defaults and helpers for the scoreboarded register file.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int REG_ZERO   = 0;

    // Low bit of port i's field inside a packed per-port vector of field width w.
    function automatic int slice_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
// ============================================================================
//  Module   : reg_file_scoreboard
//  Purpose  : Per-register busy bits, per-port operand readiness, WAW flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [2**ADDR_W-1:0]     busy_vec,
    output logic                     waw_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_zeroAddr = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busyNext;
    logic [NUM_RD-1:0] r_rdBusy;
    logic              r_wawErr;
    logic              w_wbValid;
    logic              w_rsvValid;
    logic              w_wawHit;
    logic [ADDR_W-1:0] w_rdAddr [NUM_RD];

    generate
        for (genvar g = 0; g < NUM_RD; g++) begin : g_rdAddr
            assign w_rdAddr[g] = rd_addr[slice_lo(g, ADDR_W) +: ADDR_W];
        end
    endgenerate

    assign w_wbValid  = we && (wr_addr != c_zeroAddr);
    assign w_rsvValid = rsv_en && !flush && (rsv_addr != c_zeroAddr);
    // Re-reserving a busy register is only legal when its writeback lands on the same edge.
    assign w_wawHit   = w_rsvValid && r_busy[rsv_addr]
                        && !(w_wbValid && (wr_addr == rsv_addr));

    always_comb begin
        w_busyNext = r_busy;
        if (flush) begin
            w_busyNext = '0;
        end else begin
            if (w_wbValid) begin
                w_busyNext[wr_addr] = 1'b0;
            end
            if (w_rsvValid) begin
                w_busyNext[rsv_addr] = 1'b1;
            end
        end
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= '0;
            r_rdBusy <= '0;
            r_wawErr <= 1'b0;
        end else begin
            r_busy <= w_busyNext;
            if (w_wawHit) begin
                r_wawErr <= 1'b1;
            end
            for (int i = 0; i < NUM_RD; i++) begin
                r_rdBusy[i] <= (w_rdAddr[i] != c_zeroAddr) && r_busy[w_rdAddr[i]]
                               && !(w_wbValid && (wr_addr == w_rdAddr[i]));
            end
        end
    end

    assign rd_busy  = r_rdBusy;
    assign busy_vec = r_busy;
    assign waw_err  = r_wawErr;

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
//  Module   : reg_file_sb
//  Purpose  : Multi-port register file with write bypass and busy scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush,
    output logic [2**ADDR_W-1:0]     busy_vec,
    output logic                     waw_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_zeroAddr = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [NUM_RD*DATA_W-1:0] r_rdData;
    logic [ADDR_W-1:0]        w_rdAddr [NUM_RD];
    logic                     w_wrValid;

    generate
        for (genvar g = 0; g < NUM_RD; g++) begin : g_rdAddr
            assign w_rdAddr[g] = rd_addr[slice_lo(g, ADDR_W) +: ADDR_W];
        end
    endgenerate

    assign w_wrValid = we && (wr_addr != c_zeroAddr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_rdData <= '0;
        end else begin
            if (w_wrValid) begin
                r_mem[wr_addr] <= wr_data;
            end
            for (int i = 0; i < NUM_RD; i++) begin
                if (w_rdAddr[i] == c_zeroAddr) begin
                    r_rdData[slice_lo(i, DATA_W) +: DATA_W] <= '0;
                end else if (w_wrValid && (wr_addr == w_rdAddr[i])) begin
                    r_rdData[slice_lo(i, DATA_W) +: DATA_W] <= wr_data;
                end else begin
                    r_rdData[slice_lo(i, DATA_W) +: DATA_W] <= r_mem[w_rdAddr[i]];
                end
            end
        end
    end

    assign rd_data = r_rdData;

    reg_file_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .we       (we),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec),
        .waw_err  (waw_err)
    );

endmodule

`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file for the pipelined MIPS core, with a built-in register scoreboard. It has NUM_RD registered read ports, one write port with write-to-read bypass, and register 0 hardwired to zero. Per-register busy bits are set when the ID stage reserves a destination and cleared when WB writes it back, so the hazard unit can stall on operand readiness. It replaces the fixed 2-read / 32x32 register file and moves reads from negedge to posedge.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (>=1)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data, same packing
rd_busy  out  NUM_RD  registered: operand i not yet written back
we  in  1  write enable (WB stage)
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rsv_en  in  1  reserve destination (ID issue)
rsv_addr  in  ADDR_W  register to mark busy
flush  in  1  clear all busy bits (pipeline flush)
busy_vec  out  2**ADDR_W  current busy bits; bit 0 always 0
waw_err  out  1  sticky error flag

Behaviour:
- Reset: when rst_n=0 at posedge, all registers, busy bits, rd_data, rd_busy and waw_err clear to 0. Reset overrides every other input in that cycle.
- Write: at posedge, if we=1 and wr_addr!=0, then mem[wr_addr] <= wr_data. Writes to address 0 are dropped.
- Read: 1-cycle latency. At posedge, for each port i with a = rd_addr[i]:
  - a==0 -> rd_data[i] <= 0.
  - else if we and wr_addr==a -> rd_data[i] <= wr_data (bypass).
  - else -> rd_data[i] <= mem[a].
- Multiple ports may read the same address; all return the same value.
- rd_busy[i] <= busy[a] & ~(we & wr_addr==a). It reflects the same-edge writeback clear but not a same-edge reservation. It is 0 for a==0.
- Busy update at posedge, in priority order:
  1. flush=1: busy <= 0. rsv_en is ignored this cycle; we still writes the array.
  2. Otherwise, we with wr_addr!=0 clears busy[wr_addr].
  3. Then rsv_en with rsv_addr!=0 sets busy[rsv_addr]. Reserve wins over a same-address clear in the same cycle.
- Writeback to a non-busy register is legal: a plain write with no error.
- waw_err is set (sticky until reset) when rsv_en=1, flush=0, rsv_addr!=0, busy[rsv_addr]=1, and no same-cycle writeback to rsv_addr is present.
- busy_vec is the registered busy array driven directly; bit 0 is tied to 0.
- No combinational path from any input to any output.

Decomposition:
- Package reg_file_pkg holds:
  - default localparams (DATA_W=32, ADDR_W=5, NUM_RD=2);
  - REG_ZERO = 0;
  - a function to extract port i's slice from the packed address and data vectors.
- Sub-module reg_file_scoreboard owns the busy array, flush/clear/set priority and waw_err logic.
- The top level keeps the data array, bypass muxes and read registers.

Test Plan:
- Reset, then read r0..r3 on both ports -> all rd_data=0, rd_busy=0, busy_vec=0, waw_err=0.
- Write r5=0x1A3BEE22 while port0 reads r5 in the same cycle -> next cycle rd_data[0]=0x1A3BEE22 via bypass. Write r0=0xFFFF_FFFF -> reading r0 returns 0.
- Reserve r3, then read r3 the following cycle -> rd_busy[0]=1 and busy_vec[3]=1. Writeback r3=40 while port1 reads r3 -> next cycle rd_data[1]=40, rd_busy[1]=0, busy_vec[3]=0.
- Same cycle: we to r7 and rsv_en on r7 (r7 busy) -> busy_vec[7]=1, waw_err=0. Next cycle rsv_en on r7 again with no writeback -> waw_err=1 and it stays 1 until rst_n=0.
- Reserve r2, r4, r9; then flush=1 together with rsv_en on r10 -> busy_vec=0 (r10 not set). A simultaneous we of r2=25 still lands: a later read of r2 returns 25.
- Drive rst_n=0 for one cycle mid-sequence with busy bits set, waw_err=1 and registers holding data -> next cycle every output is 0 and reading any register returns 0.
